// File: rtl/membus_byte_responder.sv
// Memory-side responder for the byte-serial pin bus.
// It collects a 4-beat address/write word, then returns a 4-beat read word from a small word RAM.
module membus_byte_responder #(
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       bus_rw,
    input  logic [7:0] bus_addr,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       bus_rdata_oe,
    output logic       busy,
    output logic       err
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [3:0] {
        S_IDLE, S_A0, S_A1, S_A2, S_A3, S_D0, S_D1, S_D2, S_D3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] rword_q, rword_d;
    logic        rd_q, rd_d;
    logic        err_q, err_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        oe_q, oe_d;
    logic [31:0] mem_q [DEPTH];

    logic [31:0]           full_addr;
    logic [31:0]           full_wd;
    logic [31:0]           off;
    logic                  hit;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  we;
    logic                  unused_bits;

    // Beat A3 decodes with the live top byte, so the lookup costs no extra cycle.
    always_comb begin
        full_addr = {bus_addr, addr_q[23:0]};
        full_wd   = {bus_wdata, wd_q[23:0]};
        off       = full_addr - BASE_ADDR;
        hit       = (off[31:DEPTH_LOG2+2] == '0);
        idx       = off[DEPTH_LOG2+1:2];
    end

    assign unused_bits = ^{off[1:0], addr_q[31:24], wd_q[31:24]};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        rword_d = rword_q;
        rd_d    = rd_q;
        err_d   = err_q;
        we      = 1'b0;
        if (frame_start) begin
            state_d = S_A0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_A0: begin
                    addr_d[7:0] = bus_addr;
                    wd_d[7:0]   = bus_wdata;
                    state_d     = S_A1;
                end
                S_A1: begin
                    addr_d[15:8] = bus_addr;
                    wd_d[15:8]   = bus_wdata;
                    state_d      = S_A2;
                end
                S_A2: begin
                    addr_d[23:16] = bus_addr;
                    wd_d[23:16]   = bus_wdata;
                    state_d       = S_A3;
                end
                S_A3: begin
                    addr_d[31:24] = bus_addr;
                    wd_d[31:24]   = bus_wdata;
                    rd_d          = bus_rw;
                    state_d       = S_D0;
                    if (!hit) err_d = 1'b1;
                    if (bus_rw) rword_d = hit ? mem_q[idx] : 32'h0;
                    else        we      = hit;
                end
                S_D0:    state_d = S_D1;
                S_D1:    state_d = S_D2;
                S_D2:    state_d = S_D3;
                S_D3:    state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Read bytes are set up from next-state values so they appear exactly in Dk.
    always_comb begin
        rdata_d = 8'h00;
        oe_d    = 1'b0;
        if (rd_d) begin
            case (state_d)
                S_D0:    begin rdata_d = rword_d[7:0];   oe_d = 1'b1; end
                S_D1:    begin rdata_d = rword_d[15:8];  oe_d = 1'b1; end
                S_D2:    begin rdata_d = rword_d[23:16]; oe_d = 1'b1; end
                S_D3:    begin rdata_d = rword_d[31:24]; oe_d = 1'b1; end
                default: begin rdata_d = 8'h00;          oe_d = 1'b0; end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wd_q    <= '0;
            rword_q <= '0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rword_q <= rword_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            oe_q    <= oe_d;
        end
    end

    // Flop-based RAM so that reset can clear every word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we) begin
            mem_q[idx] <= full_wd;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign err          = err_q;
    assign bus_rdata    = rdata_q;
    assign bus_rdata_oe = oe_q;
endmodule

// File: tb/tb_membus_byte_responder.sv
// Directed bench for membus_byte_responder: one instance at BASE_ADDR 0, one at 0x1000_0000.
module tb_membus_byte_responder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic       bus_rw;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic [7:0] rdata0, rdata1;
    logic       oe0, oe1, busy0, busy1, err0, err1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    membus_byte_responder #(.DEPTH_LOG2(4), .BASE_ADDR(32'h0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bus_rw(bus_rw),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(rdata0),
        .bus_rdata_oe(oe0), .busy(busy0), .err(err0)
    );

    membus_byte_responder #(.DEPTH_LOG2(4), .BASE_ADDR(32'h1000_0000)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bus_rw(bus_rw),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(rdata1),
        .bus_rdata_oe(oe1), .busy(busy1), .err(err1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One bus frame. abort_at=k raises frame_start during Ak; chain raises it during D3.
    task automatic frame(input logic rw, input logic [31:0] a, input logic [31:0] w,
                         input int abort_at, input bit chain, input bit skip_t0,
                         output logic [31:0] r0, output logic [31:0] r1,
                         output logic [3:0] oes);
        r0  = '0;
        r1  = '0;
        oes = '0;
        if (!skip_t0) begin
            @(posedge clk); #1;
            frame_start = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("oe_addr_beat", oe0, 0);
            check("busy_addr_beat", busy0, 1);
            frame_start = (k == abort_at);
            bus_addr    = a[8*k +: 8];
            bus_wdata   = w[8*k +: 8];
            bus_rw      = rw;
            if (k == abort_at) break;
        end
        if (abort_at >= 0 && abort_at < 4) begin
            @(posedge clk); #1;
            frame_start = 1'b0;
            bus_rw      = 1'b1;
            bus_addr    = 8'h00;
            bus_wdata   = 8'h00;
            repeat (8) @(posedge clk);
            #1;
            check("busy_after_abort", busy0, 0);
            $display("frame rw=%0d addr=%h wdata=%h aborted in A%0d", rw, a, w, abort_at);
            return;
        end
        for (int d = 0; d < 4; d++) begin
            @(posedge clk); #1;
            r0[8*d +: 8] = rdata0;
            r1[8*d +: 8] = rdata1;
            oes[d]       = oe0;
            if (d == 3 && chain) frame_start = 1'b1;
        end
        if (!chain) begin
            @(posedge clk); #1;
            check("oe_idle", oe0, 0);
            check("rdata_idle", rdata0, 0);
            check("busy_idle", busy0, 0);
        end
        $display("frame rw=%0d addr=%h wdata=%h rdata0=%h rdata1=%h oe=%b",
                 rw, a, w, r0, r1, oes);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r0, r1;
        logic [3:0]  oes;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        bus_rw      = 1'b0;
        bus_addr    = 8'h00;
        bus_wdata   = 8'h00;
        #12;
        check("reset_busy", busy0, 0);
        check("reset_oe", oe0, 0);
        check("reset_err", err0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: reset in the middle of a read clears outputs and RAM
        frame(1'b0, 32'h0, 32'h1234_5678, -1, 1'b0, 1'b0, r0, r1, oes);
        @(posedge clk); #1;
        frame_start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            frame_start = 1'b0;
            bus_addr    = 8'h00;
            bus_rw      = 1'b1;
        end
        @(posedge clk); #1;
        check("t1_d0_rdata", rdata0, 8'h78);
        @(posedge clk); #1;
        check("t1_d1_oe", oe0, 1);
        check("t1_d1_rdata", rdata0, 8'h56);
        #2 rst_n = 1'b0;
        #1;
        check("t1_rst_oe", oe0, 0);
        check("t1_rst_rdata", rdata0, 0);
        check("t1_rst_busy", busy0, 0);
        @(posedge clk); #1;
        check("t1_next_oe", oe0, 0);
        check("t1_next_busy", busy0, 0);
        rst_n = 1'b1;
        frame(1'b1, 32'h0, 32'h0, -1, 1'b0, 1'b0, r0, r1, oes);
        check("t1_word0_cleared", r0, 32'h0);

        // 2: write then read word 2
        frame(1'b0, 32'h8, 32'hDEAD_BEEF, -1, 1'b0, 1'b0, r0, r1, oes);
        frame(1'b1, 32'h8, 32'h0, -1, 1'b0, 1'b0, r0, r1, oes);
        check("t2_rdata", r0, 32'hDEAD_BEEF);
        check("t2_oe", {28'h0, oes}, 32'hF);
        check("t2_err", err0, 0);

        // 4: aborted write leaves RAM and err untouched
        frame(1'b0, 32'h4, 32'h1111_1111, 2, 1'b0, 1'b0, r0, r1, oes);
        frame(1'b1, 32'h4, 32'h0, -1, 1'b0, 1'b0, r0, r1, oes);
        check("t4_rdata", r0, 32'h0);
        check("t4_err", err0, 0);

        // 5: back-to-back read then write, frame_start in D3
        frame(1'b1, 32'h8, 32'h0, -1, 1'b1, 1'b0, r0, r1, oes);
        check("t5_read8", r0, 32'hDEAD_BEEF);
        frame(1'b0, 32'hC, 32'h0102_0304, -1, 1'b0, 1'b1, r0, r1, oes);
        frame(1'b1, 32'hC, 32'h0, -1, 1'b0, 1'b0, r0, r1, oes);
        check("t5_readC", r0, 32'h0102_0304);
        check("t5_oe", {28'h0, oes}, 32'hF);

        // 3: out-of-range read, sticky err, dropped write
        frame(1'b1, 32'h40, 32'h0, -1, 1'b0, 1'b0, r0, r1, oes);
        check("t3_rdata", r0, 32'h0);
        check("t3_oe", {28'h0, oes}, 32'hF);
        check("t3_err", err0, 1);
        frame(1'b0, 32'h40, 32'hFFFF_FFFF, -1, 1'b0, 1'b0, r0, r1, oes);
        frame(1'b1, 32'h0, 32'h0, -1, 1'b0, 1'b0, r0, r1, oes);
        check("t3_word0_unchanged", r0, 32'h0);
        check("t3_err_sticky", err0, 1);

        // 6: non-zero base address on the second instance
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_err0", err0, 0);
        check("t6_rst_err1", err1, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        frame(1'b0, 32'h1000_003C, 32'hCAFE_F00D, -1, 1'b0, 1'b0, r0, r1, oes);
        frame(1'b1, 32'h1000_003C, 32'h0, -1, 1'b0, 1'b0, r0, r1, oes);
        check("t6_hit_rdata", r1, 32'hCAFE_F00D);
        check("t6_hit_err", err1, 0);
        frame(1'b1, 32'h0FFF_FFFC, 32'h0, -1, 1'b0, 1'b0, r0, r1, oes);
        check("t6_miss_rdata", r1, 32'h0);
        check("t6_miss_err", err1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
